pixel_out_buffer: RTL

- Downstream of the three per-channel datapaths (R, G, B). Merges their per-channel outputs into one packed RGB pixel and buffers it in a small FIFO.
- Drives the pixel stream towards the output interface using a valid/ready handshake.
- Generates the shared datapath_ready stall signal back to all channels, so pixels still in the channel pipelines are never lost.

---
 rtl/pixel_out_buffer.sv | 115 +++++++++++
 1 files changed

// File: rtl/pixel_out_buffer.sv
// Merges the R/G/B channel outputs into packed pixels and buffers them in a small FIFO.
// pixel_out is a registered copy of the FIFO head; datapath_ready stalls the channel pipelines.
module pixel_out_buffer #(
  parameter int unsigned COLOR_W = 8,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned SLACK   = 3
) (
  input  logic                         clk,
  input  logic                         resetN,
  input  logic                         datapath_resetN,
  input  logic [COLOR_W-1:0]           r_in,
  input  logic [COLOR_W-1:0]           g_in,
  input  logic [COLOR_W-1:0]           b_in,
  input  logic                         r_valid,
  input  logic                         g_valid,
  input  logic                         b_valid,
  output logic [3*COLOR_W-1:0]         pixel_out,
  output logic                         pixel_out_valid,
  input  logic                         pixel_out_ready,
  output logic                         datapath_ready,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         overflow_err,
  output logic                         sync_err,
  input  logic                         clear_err
);

  localparam int unsigned PIX_W = 3 * COLOR_W;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CW    = AW + 1;
  localparam logic [CW:0] THRESH = (CW+1)'(DEPTH - SLACK);

  logic [PIX_W-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      rd_ptr_inc_c;

  logic [PIX_W-1:0] wdata_c;
  logic             all_valid_c;
  logic             any_valid_c;
  logic             mismatch_c;
  logic             full_c;
  logic             rd_c;
  logic             wr_eff_c;
  logic             ovf_evt_c;
  logic [CW:0]      fill_c;

  // Write/read qualification and error events for this cycle
  always_comb begin
    wdata_c      = {r_in, g_in, b_in};
    all_valid_c  = r_valid & g_valid & b_valid;
    any_valid_c  = r_valid | g_valid | b_valid;
    mismatch_c   = any_valid_c & ~all_valid_c;
    full_c       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    rd_c         = pixel_out_valid & pixel_out_ready;
    wr_eff_c     = all_valid_c & datapath_resetN & (~full_c | rd_c);
    ovf_evt_c    = all_valid_c & datapath_resetN & full_c & ~rd_c;
    rd_ptr_inc_c = rd_ptr + (AW+1)'(1);
    fill_c       = {1'b0, count} + (CW+1)'(wr_eff_c);
  end

  // Storage array; no reset needed since the pointers gate every use
  always_ff @(posedge clk) begin
    if (wr_eff_c) mem[wr_ptr[AW-1:0]] <= wdata_c;
  end

  // Sticky error flags; a new event in the clearing cycle keeps the flag set
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      sync_err     <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      sync_err     <= (sync_err & ~clear_err) | mismatch_c;
      overflow_err <= (overflow_err & ~clear_err) | ovf_evt_c;
    end
  end

  // Pointers, occupancy, stall flag and the registered head
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      datapath_ready  <= 1'b1;
      pixel_out       <= '0;
      pixel_out_valid <= 1'b0;
    end else if (!datapath_resetN) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      datapath_ready  <= 1'b1;
      pixel_out_valid <= 1'b0;
    end else begin
      if (wr_eff_c) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_c)     rd_ptr <= rd_ptr_inc_c;
      count          <= count + CW'(wr_eff_c) - CW'(rd_c);
      datapath_ready <= (fill_c <= THRESH);
      if (rd_c) begin
        // Next head comes from the array if one remains, else bypasses the incoming write
        if (count > CW'(1)) begin
          pixel_out       <= mem[rd_ptr_inc_c[AW-1:0]];
          pixel_out_valid <= 1'b1;
        end else if (wr_eff_c) begin
          pixel_out       <= wdata_c;
          pixel_out_valid <= 1'b1;
        end else begin
          pixel_out_valid <= 1'b0;
        end
      end else if (wr_eff_c && count == '0) begin
        pixel_out       <= wdata_c;
        pixel_out_valid <= 1'b1;
      end
    end
  end

endmodule
